// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction-fetch stage of the pipelined 8-bit CPU. The stage drives the
// instruction memory address from the PC and reads one byte per cycle. It
// builds 1-byte and 2-byte instructions and loads the IF/ID register that
// decode reads. It also handles hazard stalls, branch redirects (which flush
// the stage) and injection of the interrupt pseudo-instruction.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   TWO_BYTE_OPC  opcode high nibble that marks a 2-byte instruction
//   INT_IR        opcode presented to decode for an injected interrupt
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   imem_addr     out  instruction memory byte address (always the PC)
//   imem_rdata    in   byte at imem_addr, combinational in the same cycle
//   stall         in   freeze the whole stage this cycle
//   redirect_en   in   taken branch/jump/return: refetch from redirect_pc
//   redirect_pc   in   redirect target
//   int_sig       in   level interrupt request, sampled every cycle
//   ifid_valid    out  IF/ID holds a complete instruction
//   ifid_ir       out  opcode byte
//   ifid_imm      out  second byte of a 2-byte instruction, else 0
//   ifid_pc_next  out  address after the instruction (return address)
//   ifid_is_int   out  IF/ID entry is an injected interrupt
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter logic [3:0] TWO_BYTE_OPC = 4'hC,
  parameter logic [7:0] INT_IR       = 8'hBC
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       stall,
  input  logic       redirect_en,
  input  logic [7:0] redirect_pc,
  input  logic       int_sig,
  output logic       ifid_valid,
  output logic [7:0] ifid_ir,
  output logic [7:0] ifid_imm,
  output logic [7:0] ifid_pc_next,
  output logic       ifid_is_int
);

  // F1 fetches an opcode byte. F2 fetches the second byte of a 2-byte
  // instruction.
  localparam logic [0:0] ST_F1 = 1'b0;
  localparam logic [0:0] ST_F2 = 1'b1;

  logic [7:0] pc_q,       pc_d;
  logic [0:0] state_q,    state_d;
  logic [7:0] ir_hold_q,  ir_hold_d;
  logic       int_pend_q, int_pend_d;
  logic       valid_q,    valid_d;
  logic [7:0] ir_q,       ir_d;
  logic [7:0] imm_q,      imm_d;
  logic [7:0] pcn_q,      pcn_d;
  logic       is_int_q,   is_int_d;

  logic [7:0] pc_inc;
  logic       opc_two_byte;
  logic       inject;

  // The 8-bit add wraps 8'hFF to 8'h00. A 2-byte opcode at 8'hFF therefore
  // takes its second byte from 8'h00 with no extra logic.
  assign pc_inc       = pc_q + 8'd1;
  assign opc_two_byte = (imem_rdata[7:4] == TWO_BYTE_OPC);

  // Injection happens only between instructions (F1), so a 2-byte
  // instruction is never split. A redirect or stall defers the injection.
  assign inject = (state_q == ST_F1) && int_pend_q && !stall && !redirect_en;

  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    ir_hold_d = ir_hold_q;
    valid_d   = valid_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    pcn_d     = pcn_q;
    is_int_d  = is_int_q;

    // A pending request survives stalls and redirects. Only injection
    // consumes it. A request that is still asserted in the injection cycle
    // re-arms it, because the input is a level.
    int_pend_d = int_sig | (int_pend_q & ~inject);

    if (redirect_en) begin
      // Flush: any half-fetched 2-byte instruction is dropped.
      pc_d     = redirect_pc;
      state_d  = ST_F1;
      valid_d  = 1'b0;
      is_int_d = 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_F1: begin
          if (inject) begin
            // The return address is the opcode that has not been fetched,
            // so the PC does not advance.
            ir_d     = INT_IR;
            imm_d    = 8'h00;
            pcn_d    = pc_q;
            is_int_d = 1'b1;
            valid_d  = 1'b1;
          end else if (opc_two_byte) begin
            // Hold the opcode and insert a bubble while the second byte
            // is fetched.
            ir_hold_d = imem_rdata;
            pc_d      = pc_inc;
            state_d   = ST_F2;
            valid_d   = 1'b0;
            is_int_d  = 1'b0;
          end else begin
            ir_d     = imem_rdata;
            imm_d    = 8'h00;
            pcn_d    = pc_inc;
            is_int_d = 1'b0;
            valid_d  = 1'b1;
            pc_d     = pc_inc;
          end
        end
        default: begin
          ir_d     = ir_hold_q;
          imm_d    = imem_rdata;
          pcn_d    = pc_inc;
          is_int_d = 1'b0;
          valid_d  = 1'b1;
          pc_d     = pc_inc;
          state_d  = ST_F1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_F1;
      ir_hold_q  <= 8'h00;
      int_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      ir_q       <= 8'h00;
      imm_q      <= 8'h00;
      pcn_q      <= 8'h00;
      is_int_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      ir_hold_q  <= ir_hold_d;
      int_pend_q <= int_pend_d;
      valid_q    <= valid_d;
      ir_q       <= ir_d;
      imm_q      <= imm_d;
      pcn_q      <= pcn_d;
      is_int_q   <= is_int_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_valid   = valid_q;
  assign ifid_ir      = ir_q;
  assign ifid_imm     = imm_q;
  assign ifid_pc_next = pcn_q;
  assign ifid_is_int  = is_int_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       stall = 1'b0;
  logic       redirect_en = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       int_sig = 1'b0;
  logic       ifid_valid;
  logic [7:0] ifid_ir;
  logic [7:0] ifid_imm;
  logic [7:0] ifid_pc_next;
  logic       ifid_is_int;

  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the fetched byte stream, with an optional "first byte
  // waiting for its partner" slot.
  logic [7:0] m_pc;
  bit         m_have_first;
  logic [7:0] m_first;
  bit         m_pend;
  bit         m_valid;
  logic [7:0] m_ir, m_imm, m_pcn;
  bit         m_isint;

  assign imem_rdata = mem[imem_addr];

  instr_fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .int_sig(int_sig), .ifid_valid(ifid_valid), .ifid_ir(ifid_ir),
    .ifid_imm(ifid_imm), .ifid_pc_next(ifid_pc_next), .ifid_is_int(ifid_is_int)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 8'h00; m_have_first = 0; m_first = 8'h00; m_pend = 0;
    m_valid = 0; m_ir = 8'h00; m_imm = 8'h00; m_pcn = 8'h00; m_isint = 0;
  endtask

  task automatic model_cycle();
    logic [7:0] b;
    bit took_int;
    took_int = 0;
    b = mem[m_pc];
    if (redirect_en) begin
      m_pc = redirect_pc; m_have_first = 0; m_valid = 0; m_isint = 0;
    end else if (!stall) begin
      if (m_have_first) begin
        m_ir = m_first; m_imm = b; m_pcn = m_pc + 8'd1; m_pc = m_pc + 8'd1;
        m_have_first = 0; m_valid = 1; m_isint = 0;
      end else if (m_pend) begin
        m_ir = 8'hBC; m_imm = 8'h00; m_pcn = m_pc; m_valid = 1; m_isint = 1;
        took_int = 1;
      end else if (b[7:4] == 4'hC) begin
        m_first = b; m_have_first = 1; m_pc = m_pc + 8'd1; m_valid = 0; m_isint = 0;
      end else begin
        m_ir = b; m_imm = 8'h00; m_pcn = m_pc + 8'd1; m_pc = m_pc + 8'd1;
        m_valid = 1; m_isint = 0;
      end
    end
    if (took_int) m_pend = 0;
    if (int_sig) m_pend = 1;
  endtask

  // Advance one clock. The model consumes the same inputs the DUT sees at
  // the edge. Sampling happens 1 time unit after the edge.
  task automatic step();
    if (rst) model_reset(); else model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    n_tests++;
    if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", ifid_valid); end
    n_tests++;
    if ({ifid_ir, ifid_imm, ifid_pc_next} !== 24'h0) begin
      n_fail++; $display("FAIL reset_ifid got %h want 000000", {ifid_ir, ifid_imm, ifid_pc_next});
    end
    n_tests++;
    if ({ifid_is_int, imem_addr} !== 9'h000) begin
      n_fail++; $display("FAIL reset_pc got isint=%0h addr=%h want 0/00", ifid_is_int, imem_addr);
    end
  endtask

  task automatic test_two_byte_and_one_byte();
    mem[0] = 8'hC0; mem[1] = 8'h14; mem[2] = 8'h24; mem[3] = 8'h35;
    rst = 1'b0;
    step();
    n_tests++;
    if ({ifid_valid, imem_addr} !== {1'b0, 8'h01}) begin
      n_fail++; $display("FAIL ldm_bubble got v=%0h addr=%h want 0/01", ifid_valid, imem_addr);
    end
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, ifid_is_int} !== {1'b1, 8'hC0, 8'h14, 8'h02, 1'b0}) begin
      n_fail++; $display("FAIL ldm_present got v=%0h ir=%h imm=%h pcn=%h want 1 C0 14 02",
                         ifid_valid, ifid_ir, ifid_imm, ifid_pc_next);
    end
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, imem_addr} !== {1'b1, 8'h24, 8'h00, 8'h03, 8'h03}) begin
      n_fail++; $display("FAIL one_byte got v=%0h ir=%h imm=%h pcn=%h addr=%h want 1 24 00 03 03",
                         ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, imem_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, imem_addr} !== {1'b1, 8'h24, 8'h00, 8'h03, 8'h03}) begin
        n_fail++; $display("FAIL stall_hold cyc%0d got v=%0h ir=%h pcn=%h addr=%h want 1 24 03 03",
                           i, ifid_valid, ifid_ir, ifid_pc_next, imem_addr);
      end
    end
    stall = 1'b0;
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_pc_next} !== {1'b1, 8'h35, 8'h04}) begin
      n_fail++; $display("FAIL stall_resume got v=%0h ir=%h pcn=%h want 1 35 04", ifid_valid, ifid_ir, ifid_pc_next);
    end
  endtask

  task automatic test_redirect_flush();
    mem[8'h06] = 8'hC1; mem[8'h07] = 8'h32; mem[8'h10] = 8'h40;
    redirect_en = 1'b1; redirect_pc = 8'h06;
    step();
    redirect_en = 1'b0;
    step();
    n_tests++;
    if ({ifid_valid, imem_addr} !== {1'b0, 8'h07}) begin
      n_fail++; $display("FAIL redir_setup got v=%0h addr=%h want 0/07", ifid_valid, imem_addr);
    end
    redirect_en = 1'b1; redirect_pc = 8'h10;
    step();
    redirect_en = 1'b0;
    n_tests++;
    if ({ifid_valid, ifid_is_int, imem_addr} !== {1'b0, 1'b0, 8'h10}) begin
      n_fail++; $display("FAIL redir_flush got v=%0h isint=%0h addr=%h want 0 0 10", ifid_valid, ifid_is_int, imem_addr);
    end
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next} !== {1'b1, 8'h40, 8'h00, 8'h11}) begin
      n_fail++; $display("FAIL redir_target got v=%0h ir=%h imm=%h pcn=%h want 1 40 00 11",
                         ifid_valid, ifid_ir, ifid_imm, ifid_pc_next);
    end
  endtask

  task automatic test_interrupt();
    redirect_en = 1'b1; redirect_pc = 8'h00;
    step();
    redirect_en = 1'b0;
    step();                  // F1 at 00 picks up C0
    int_sig = 1'b1;
    step();                  // F2: LDM completes, request latched
    int_sig = 1'b0;
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_is_int} !== {1'b1, 8'hC0, 8'h14, 1'b0}) begin
      n_fail++; $display("FAIL int_ldm_first got v=%0h ir=%h imm=%h isint=%0h want 1 C0 14 0",
                         ifid_valid, ifid_ir, ifid_imm, ifid_is_int);
    end
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, ifid_is_int, imem_addr} !==
        {1'b1, 8'hBC, 8'h00, 8'h02, 1'b1, 8'h02}) begin
      n_fail++; $display("FAIL int_inject got v=%0h ir=%h imm=%h pcn=%h isint=%0h addr=%h want 1 BC 00 02 1 02",
                         ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, ifid_is_int, imem_addr);
    end
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_pc_next, ifid_is_int} !== {1'b1, 8'h24, 8'h03, 1'b0}) begin
      n_fail++; $display("FAIL int_after got v=%0h ir=%h pcn=%h isint=%0h want 1 24 03 0",
                         ifid_valid, ifid_ir, ifid_pc_next, ifid_is_int);
    end
  endtask

  task automatic test_pc_wrap();
    mem[8'hFF] = 8'hC2; mem[8'h00] = 8'h50;
    redirect_en = 1'b1; redirect_pc = 8'hFF;
    step();
    redirect_en = 1'b0;
    step();
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, imem_addr} !== {1'b1, 8'hC2, 8'h50, 8'h01, 8'h01}) begin
      n_fail++; $display("FAIL pc_wrap got v=%0h ir=%h imm=%h pcn=%h addr=%h want 1 C2 50 01 01",
                         ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, imem_addr);
    end
  endtask

  task automatic test_async_reset_mid_f2();
    mem[8'h20] = 8'hC5; mem[8'h21] = 8'h66;
    redirect_en = 1'b1; redirect_pc = 8'h20;
    step();
    redirect_en = 1'b0;
    step();                  // now in F2 at 21
    rst = 1'b1;
    #1;                      // no clock edge yet
    model_reset();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, ifid_is_int, imem_addr} !== 33'h0) begin
      n_fail++; $display("FAIL async_reset got v=%0h ir=%h imm=%h pcn=%h isint=%0h addr=%h want all 0",
                         ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, ifid_is_int, imem_addr);
    end
    step();
    rst = 1'b0;
    step();
    n_tests++;
    if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, imem_addr} !== {1'b1, 8'h50, 8'h00, 8'h01, 8'h01}) begin
      n_fail++; $display("FAIL reset_restart got v=%0h ir=%h imm=%h pcn=%h addr=%h want 1 50 00 01 01",
                         ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, imem_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 2) == 0) mem[i] = {4'hC, 4'($urandom_range(0, 15))};
      else mem[i] = 8'($urandom_range(0, 255));
    end
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 4) == 0);
      redirect_en = ($urandom_range(0, 9) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      int_sig     = ($urandom_range(0, 11) == 0);
      step();
      n_tests++;
      if (m_valid) begin
        if ({ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, ifid_is_int, imem_addr} !==
            {1'b1, m_ir, m_imm, m_pcn, m_isint, m_pc}) begin
          n_fail++; $display("FAIL rand_cyc%0d got v=%0h ir=%h imm=%h pcn=%h isint=%0h addr=%h want 1 %h %h %h %0h %h",
                             c, ifid_valid, ifid_ir, ifid_imm, ifid_pc_next, ifid_is_int, imem_addr,
                             m_ir, m_imm, m_pcn, m_isint, m_pc);
        end
      end else begin
        if ({ifid_valid, ifid_is_int, imem_addr} !== {1'b0, 1'b0, m_pc}) begin
          n_fail++; $display("FAIL rand_cyc%0d got v=%0h isint=%0h addr=%h want 0 0 %h",
                             c, ifid_valid, ifid_is_int, imem_addr, m_pc);
        end
      end
    end
    stall = 1'b0; redirect_en = 1'b0; int_sig = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    model_reset();
    test_reset();
    test_two_byte_and_one_byte();
    test_stall();
    test_redirect_flush();
    test_interrupt();
    test_pc_wrap();
    test_async_reset_mid_f2();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
